// File: rtl/uart_cdc_handshake_pkg.sv
`timescale 1ns/1ps
// uart_cdc_handshake_pkg: shared types and constants for the UART RX -> system CDC bridge.
// Defines the classified RX message bundle carried across the crossing, its width,
// and the default synchroniser depth used by every flop chain in the bridge.
package uart_cdc_handshake_pkg;

   typedef enum logic [7:0] {
      MSG_NONE  = 8'h00,
      MSG_WRITE = 8'h01,
      MSG_READ  = 8'h02,
      MSG_PIXEL = 8'h03,
      MSG_BURST = 8'h04
   } msg_type_e;

   // Field widths chosen so the bundle packs to exactly 256 bits.
   typedef struct packed {
      msg_type_e   msg_type;
      logic [15:0] addr;
      logic [15:0] offset;
      logic [31:0] data_hi;
      logic [31:0] data_lo;
      logic [15:0] height;
      logic [15:0] width;
      logic [7:0]  pixel_r;
      logic [7:0]  pixel_g;
      logic [7:0]  pixel_b;
      logic [31:0] burst_r;
      logic [31:0] burst_g;
      logic [31:0] burst_b;
   } rx_msg_bundle_t;

   localparam int RX_BUNDLE_W     = $bits(rx_msg_bundle_t);
   localparam int CDC_SYNC_STAGES = 2;

endpackage

// File: rtl/uart_cdc_handshake_sync.sv
`timescale 1ns/1ps
// cdc_sync_ff: multi-flop synchroniser chain, asynchronous active-low reset to 0.
// Ports: clk/rst_n of the destination domain, d = asynchronous input, q = synchronised
// output delayed by STAGES clk edges. Each bit is synchronised independently.
module cdc_sync_ff
   import uart_cdc_handshake_pkg::*;
#(
   parameter int STAGES = CDC_SYNC_STAGES,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Marked so the CDC/implementation tools keep these flops adjacent and
   // treat the first stage as the metastability capture point.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_cdc_handshake.sv
`timescale 1ns/1ps
// uart_cdc_handshake: flow-controlled bundle crossing clk_rx -> clk_sys using a toggle
// req/ack handshake, plus level flags (rx -> sys) and event pulses (sys -> rx).
// Ports: rx_valid/rx_data/rx_ready bundle input and rx_lvl/rx_pulse on clk_rx;
// sys_valid/sys_data/sys_ready bundle output, sys_lvl, sys_pulse, sys_xfer_cnt on clk_sys.
module uart_cdc_handshake
   import uart_cdc_handshake_pkg::*;
#(
   parameter int DATA_W      = RX_BUNDLE_W,
   parameter int SYNC_STAGES = CDC_SYNC_STAGES,
   parameter int NUM_LVL     = 2,
   parameter int NUM_PULSE   = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk_sys,
   input  logic                 rst_sys_n,
   input  logic                 clk_rx,
   input  logic                 rst_rx_n,
   input  logic                 rx_valid,
   input  logic [DATA_W-1:0]    rx_data,
   output logic                 rx_ready,
   input  logic [NUM_LVL-1:0]   rx_lvl,
   output logic [NUM_PULSE-1:0] rx_pulse,
   output logic                 sys_valid,
   output logic [DATA_W-1:0]    sys_data,
   input  logic                 sys_ready,
   output logic [NUM_LVL-1:0]   sys_lvl,
   input  logic [NUM_PULSE-1:0] sys_pulse,
   output logic [CNT_W-1:0]     sys_xfer_cnt
);

   logic [DATA_W-1:0]    hold_q;
   logic                 req_tgl;
   logic                 req_sync;
   logic                 req_seen;
   logic                 ack_tgl;
   logic                 ack_sync;
   logic [NUM_PULSE-1:0] p_tgl;
   logic [NUM_PULSE-1:0] p_sync;
   logic [NUM_PULSE-1:0] p_prev;

   // ---------------- RX domain: accept one bundle, wait for its ack ----------------
   // hold_q is only written on an accepted handshake, so it stays quasi-static
   // for the whole time the SYS side may be sampling it.
   always_ff @(posedge clk_rx or negedge rst_rx_n) begin
      if (!rst_rx_n) begin
         hold_q   <= '0;
         req_tgl  <= 1'b0;
         rx_ready <= 1'b1;
      end else if (rx_valid && rx_ready) begin
         hold_q   <= rx_data;
         req_tgl  <= ~req_tgl;
         rx_ready <= 1'b0;
      end else if (!rx_ready && (ack_sync == req_tgl)) begin
         // ack toggle has caught up with the req toggle: the bundle was consumed.
         rx_ready <= 1'b1;
      end
   end

   cdc_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ack_sync (
      .clk   (clk_rx),
      .rst_n (rst_rx_n),
      .d     (ack_tgl),
      .q     (ack_sync)
   );

   // Pulse events: each toggle flip seen after synchronisation becomes one cycle.
   cdc_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(NUM_PULSE)) u_pulse_sync (
      .clk   (clk_rx),
      .rst_n (rst_rx_n),
      .d     (p_tgl),
      .q     (p_sync)
   );

   always_ff @(posedge clk_rx or negedge rst_rx_n) begin
      if (!rst_rx_n) begin
         p_prev <= '0;
      end else begin
         p_prev <= p_sync;
      end
   end

   assign rx_pulse = p_sync ^ p_prev;

   // ---------------- SYS domain: present bundle, ack on consume ----------------
   cdc_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_req_sync (
      .clk   (clk_sys),
      .rst_n (rst_sys_n),
      .d     (req_tgl),
      .q     (req_sync)
   );

   cdc_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(NUM_LVL)) u_lvl_sync (
      .clk   (clk_sys),
      .rst_n (rst_sys_n),
      .d     (rx_lvl),
      .q     (sys_lvl)
   );

   // A consume and a new req edge never share an edge (one bundle in flight),
   // so the two updates below never conflict on sys_valid.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         sys_valid    <= 1'b0;
         sys_data     <= '0;
         req_seen     <= 1'b0;
         ack_tgl      <= 1'b0;
         sys_xfer_cnt <= '0;
      end else begin
         if (sys_valid && sys_ready) begin
            sys_valid    <= 1'b0;
            ack_tgl      <= ~ack_tgl;
            sys_xfer_cnt <= sys_xfer_cnt + CNT_W'(1);
         end
         if (req_sync != req_seen) begin
            // hold_q has been stable for SYNC_STAGES clk_sys edges by now.
            sys_data  <= hold_q;
            sys_valid <= 1'b1;
            req_seen  <= req_sync;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         p_tgl <= '0;
      end else begin
         p_tgl <= p_tgl ^ sys_pulse;
      end
   end

endmodule

// File: tb/tb_uart_cdc_handshake.sv
`timescale 1ns/1ps
// Bench for uart_cdc_handshake: randomized bundle traffic against a queue-based
// reference, plus directed backpressure, reset, counter wrap, level and pulse cases,
// run at two clock ratios.
module tb_uart_cdc_handshake;

   localparam int DW   = 256;
   localparam int SYNC = 2;
   localparam int NL   = 2;
   localparam int NP   = 2;
   localparam int CW   = 4;

   logic          clk_sys = 1'b0;
   logic          clk_rx = 1'b0;
   logic          rst_sys_n = 1'b0;
   logic          rst_rx_n = 1'b0;
   logic          rx_valid = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_ready;
   logic [NL-1:0] rx_lvl = '0;
   logic [NP-1:0] rx_pulse;
   logic          sys_valid;
   logic [DW-1:0] sys_data;
   logic          sys_ready = 1'b0;
   logic [NL-1:0] sys_lvl;
   logic [NP-1:0] sys_pulse = '0;
   logic [CW-1:0] sys_xfer_cnt;

   int  checks = 0;
   int  failures = 0;
   real rx_half = 2.841;
   real sys_half = 5.0;
   bit  in_rst = 1'b1;
   int  rdy_mode = 0;
   int  sys_pos = 0;

   // Reference model: bundles accepted but not yet delivered, in order.
   logic [DW-1:0] exp_q[$];
   int            acc_q[$];
   logic [DW-1:0] cur = '0;
   bit            hold = 1'b0;
   int            accepted = 0;
   int            consumed = 0;
   int            m_cnt = 0;

   uart_cdc_handshake #(
      .DATA_W(DW), .SYNC_STAGES(SYNC), .NUM_LVL(NL), .NUM_PULSE(NP), .CNT_W(CW)
   ) dut (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .clk_rx(clk_rx), .rst_rx_n(rst_rx_n),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .rx_lvl(rx_lvl), .rx_pulse(rx_pulse),
      .sys_valid(sys_valid), .sys_data(sys_data), .sys_ready(sys_ready),
      .sys_lvl(sys_lvl), .sys_pulse(sys_pulse), .sys_xfer_cnt(sys_xfer_cnt)
   );

   initial forever #(rx_half) clk_rx = ~clk_rx;
   initial forever #(sys_half) clk_sys = ~clk_sys;
   initial forever begin
      @(posedge clk_sys);
      sys_pos = sys_pos + 1;
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // SYS-side driver and checker: picks sys_ready, then checks the DUT against the queue.
   initial forever begin
      @(negedge clk_sys);
      if (!in_rst) begin
         case (rdy_mode)
            0:       sys_ready = 1'b0;
            1:       sys_ready = 1'b1;
            default: sys_ready = 1'($urandom_range(0, 1));
         endcase
         chk("xfer_cnt", DW'(sys_xfer_cnt), DW'(m_cnt % (1 << CW)));
         if (sys_valid) begin
            if (!hold) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL spurious_valid actual=1 required=0");
               end else begin
                  int lat;
                  lat = sys_pos - acc_q[0];
                  if (lat < SYNC + 1 || lat > SYNC + 2) begin
                     failures++;
                     $display("FAIL valid_latency actual=%0d required=%0d..%0d", lat, SYNC + 1, SYNC + 2);
                  end
                  chk("new_data", sys_data, exp_q[0]);
                  cur = exp_q[0];
               end
            end else begin
               chk("held_data", sys_data, cur);
            end
            if (sys_ready) begin
               if (exp_q.size() > 0) begin
                  void'(exp_q.pop_front());
                  void'(acc_q.pop_front());
               end
               consumed++;
               m_cnt++;
            end
            hold = !sys_ready;
         end else begin
            if (hold) chk("valid_held", DW'(sys_valid), DW'(1));
            chk("idle_data", sys_data, cur);
            hold = 1'b0;
         end
      end
   end

   // RX side: the bridge must not offer ready while a bundle is outstanding.
   initial forever begin
      @(negedge clk_rx);
      if (!in_rst && accepted != consumed) chk("rx_ready_low", DW'(rx_ready), DW'(0));
   end

   task automatic send(input logic [DW-1:0] d);
      int n = 0;
      @(negedge clk_rx);
      rx_data  = d;
      rx_valid = 1'b1;
      while (!rx_ready && n < 2000) begin
         @(negedge clk_rx);
         n++;
      end
      checks++;
      if (!rx_ready) begin
         failures++;
         $display("FAIL rx_ready_timeout actual=0 required=1");
         rx_valid = 1'b0;
      end else begin
         @(posedge clk_rx);
         exp_q.push_back(d);
         acc_q.push_back(sys_pos);
         accepted++;
         @(negedge clk_rx);
         rx_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (!(exp_q.size() == 0 && rx_ready && !sys_valid) && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("drain", DW'(exp_q.size() == 0 && rx_ready && !sys_valid), DW'(1));
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!sys_valid && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      chk("wait_valid", DW'(sys_valid), DW'(1));
   endtask

   task automatic do_reset();
      in_rst    = 1'b1;
      rx_valid  = 1'b0;
      sys_pulse = '0;
      rx_lvl    = '0;
      #0.3;
      rst_sys_n = 1'b0;
      rst_rx_n  = 1'b0;
      repeat (6) @(negedge clk_rx);
      repeat (6) @(negedge clk_sys);
      chk("rst_rx_ready", DW'(rx_ready), DW'(1));
      chk("rst_rx_pulse", DW'(rx_pulse), DW'(0));
      chk("rst_sys_valid", DW'(sys_valid), DW'(0));
      chk("rst_sys_data", sys_data, DW'(0));
      chk("rst_sys_lvl", DW'(sys_lvl), DW'(0));
      chk("rst_cnt", DW'(sys_xfer_cnt), DW'(0));
      exp_q.delete();
      acc_q.delete();
      cur = '0; hold = 1'b0; accepted = 0; consumed = 0; m_cnt = 0;
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      rst_rx_n  = 1'b1;
      repeat (3) @(negedge clk_rx);
      @(negedge clk_sys);
      in_rst = 1'b0;
   endtask

   task automatic check_pulse(input logic [NP-1:0] pat);
      int nz = 0;
      logic [NP-1:0] seen = '0;
      @(negedge clk_sys);
      sys_pulse = pat;
      fork
         begin
            @(negedge clk_sys);
            sys_pulse = '0;
         end
         begin
            for (int i = 0; i < 24; i++) begin
               @(negedge clk_rx);
               if (rx_pulse != '0) begin
                  nz++;
                  seen = rx_pulse;
               end
            end
         end
      join
      chk("pulse_cycles", DW'(nz), DW'(1));
      chk("pulse_bits", DW'(seen), DW'(pat));
   endtask

   task automatic check_lvl();
      logic [NL-1:0] old_v, new_v;
      @(negedge clk_sys);
      old_v = rx_lvl;
      new_v = old_v ^ NL'($urandom_range(1, 3));
      chk("lvl_before", DW'(sys_lvl), DW'(old_v));
      rx_lvl = new_v;
      for (int i = 1; i < SYNC; i++) begin
         @(negedge clk_sys);
         chk("lvl_in_sync", DW'(sys_lvl), DW'(old_v));
      end
      @(negedge clk_sys);
      chk("lvl_after", DW'(sys_lvl), DW'(new_v));
   endtask

   task automatic stream(input int count);
      rdy_mode = 2;
      for (int i = 0; i < count; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk_rx);
         send(rnd());
      end
      wait_drain();
   endtask

   initial begin
      logic [DW-1:0] a5, b1, b2;
      int vals[18];
      a5 = {32{8'hA5}};

      // ---- ratio rx 176 MHz / sys 100 MHz ----
      do_reset();

      rdy_mode = 1;
      send(a5);
      wait_drain();
      chk("single_data", sys_data, a5);
      chk("single_cnt", DW'(sys_xfer_cnt), DW'(1));
      chk("single_rx_ready", DW'(rx_ready), DW'(1));

      rdy_mode = 0;
      b1 = rnd();
      b2 = rnd();
      send(b1);
      wait_valid();
      @(negedge clk_rx);
      rx_data  = b2;
      rx_valid = 1'b1;
      repeat (50) @(negedge clk_sys);
      chk("bp_valid", DW'(sys_valid), DW'(1));
      chk("bp_data", sys_data, b1);
      chk("bp_rx_ready", DW'(rx_ready), DW'(0));
      @(negedge clk_rx);
      rx_valid = 1'b0;
      rdy_mode = 1;
      send(b2);
      wait_drain();
      chk("bp_data_last", sys_data, b2);
      chk("bp_cnt", DW'(sys_xfer_cnt), DW'(3));

      rdy_mode = 0;
      send(rnd());
      wait_valid();
      do_reset();
      rdy_mode = 1;
      send(rnd());
      wait_drain();
      chk("post_rst_cnt", DW'(sys_xfer_cnt), DW'(1));

      vals[1] = 1;
      for (int k = 2; k <= 17; k++) begin
         send(rnd());
         wait_drain();
         vals[k] = int'(sys_xfer_cnt);
      end
      chk("wrap_15", DW'(vals[15]), DW'(15));
      chk("wrap_16", DW'(vals[16]), DW'(0));
      chk("wrap_17", DW'(vals[17]), DW'(1));

      stream(1000);
      chk("stream_total", DW'(m_cnt), DW'(1017));
      chk("stream_cnt", DW'(sys_xfer_cnt), DW'(9));

      check_pulse(2'b11);
      repeat (10) @(negedge clk_rx);
      check_pulse(2'b01);
      repeat (4) check_pulse(NP'($urandom_range(1, 3)));
      repeat (6) check_lvl();

      // ---- swapped ratio rx 100 MHz / sys 176 MHz ----
      in_rst   = 1'b1;
      rx_half  = 5.0;
      sys_half = 2.841;
      do_reset();
      rdy_mode = 1;
      send(a5);
      wait_drain();
      chk("swap_single_data", sys_data, a5);
      chk("swap_single_cnt", DW'(sys_xfer_cnt), DW'(1));
      stream(300);
      chk("swap_stream_total", DW'(m_cnt), DW'(301));
      chk("swap_stream_cnt", DW'(sys_xfer_cnt), DW'(13));
      check_pulse(2'b11);
      repeat (10) @(negedge clk_rx);
      check_pulse(2'b01);
      repeat (3) check_lvl();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
